// File: rtl/comparator_seq_if.sv
// Operand/result bundle for comparator_seq: the bench or host drives the master side,
// the comparator drives the slave side.
interface comparator_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             enable;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_cnt;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             out_valid;
  logic             changed;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [1:0]       state;

  modport master (
    output enable, in_valid, a, b, clr_cnt,
    input  gt, eq, lt, out_valid, changed, gt_cnt, eq_cnt, lt_cnt, state
  );

  modport slave (
    input  enable, in_valid, a, b, clr_cnt,
    output gt, eq, lt, out_valid, changed, gt_cnt, eq_cnt, lt_cnt, state
  );
endinterface

// File: rtl/comparator_seq.sv
// Registered unsigned/two's-complement magnitude comparator with ENABLE/PAUSE/RESET
// status and saturating per-result history counters.
module comparator_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned CNT_W  = 8
) (
  input logic             clk,
  input logic             reset,
  comparator_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ENABLE = 2'b00,
    ST_PAUSE  = 2'b01,
    ST_RESET  = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;
  logic             out_valid_q;
  logic             changed_q;
  logic [CNT_W-1:0] gt_cnt_q;
  logic [CNT_W-1:0] eq_cnt_q;
  logic [CNT_W-1:0] lt_cnt_q;

  logic             accept_c;
  logic             a_gt_b_c;
  logic             a_eq_b_c;
  logic [2:0]       res_c;

  // Status register: RESET only while reset is held, then tracks enable one cycle late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_PAUSE;
    if (bus.enable) state_d = ST_ENABLE;
  end

  // Magnitude compare; SIGNED selects how the MSB is interpreted.
  always_comb begin
    a_eq_b_c = (bus.a == bus.b);
    if (SIGNED != 0) a_gt_b_c = ($signed(bus.a) > $signed(bus.b));
    else             a_gt_b_c = (bus.a > bus.b);
  end

  assign accept_c = bus.enable & bus.in_valid;
  assign res_c    = {a_gt_b_c, a_eq_b_c, ~(a_gt_b_c | a_eq_b_c)};

  // Result flags hold between accepts; changed compares against the held flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      out_valid_q <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      out_valid_q <= accept_c;
      changed_q   <= accept_c && (res_c != {gt_q, eq_q, lt_q});
      if (accept_c) begin
        gt_q <= res_c[2];
        eq_q <= res_c[1];
        lt_q <= res_c[0];
      end
    end
  end

  // Clear has priority but still counts a same-cycle hit as the first event.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic clr, input logic hit);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (clr)                       nxt = hit ? CNT_ONE : '0;
    else if (hit && cur != CNT_MAX) nxt = cur + CNT_ONE;
    return nxt;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gt_cnt_q <= '0;
      eq_cnt_q <= '0;
      lt_cnt_q <= '0;
    end else begin
      gt_cnt_q <= cnt_next(gt_cnt_q, bus.clr_cnt, accept_c & res_c[2]);
      eq_cnt_q <= cnt_next(eq_cnt_q, bus.clr_cnt, accept_c & res_c[1]);
      lt_cnt_q <= cnt_next(lt_cnt_q, bus.clr_cnt, accept_c & res_c[0]);
    end
  end

  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.changed   = changed_q;
  assign bus.gt_cnt    = gt_cnt_q;
  assign bus.eq_cnt    = eq_cnt_q;
  assign bus.lt_cnt    = lt_cnt_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Scoreboard bench for comparator_seq: three instances (unsigned, signed, 2-bit counters)
// with directed vectors; a negedge monitor checks every out_valid pulse against a queue.
module tb_comparator_seq;

  typedef struct {
    logic [2:0] res;
    logic       ch;
    logic [7:0] g;
    logic [7:0] e;
    logic [7:0] l;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  comparator_seq_if #(.WIDTH(8), .CNT_W(8)) if0 ();
  comparator_seq_if #(.WIDTH(8), .CNT_W(8)) if1 ();
  comparator_seq_if #(.WIDTH(8), .CNT_W(2)) if2 ();

  comparator_seq #(.WIDTH(8), .SIGNED(0), .CNT_W(8)) u0 (.clk(clk), .reset(reset), .bus(if0));
  comparator_seq #(.WIDTH(8), .SIGNED(1), .CNT_W(8)) u1 (.clk(clk), .reset(reset), .bus(if1));
  comparator_seq #(.WIDTH(8), .SIGNED(0), .CNT_W(2)) u2 (.clk(clk), .reset(reset), .bus(if2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one sample (optionally with clr_cnt) and queue the response it must produce.
  task automatic send(input int idx, input logic [7:0] a, input logic [7:0] b,
                      input logic clr, input logic [2:0] res, input logic ch,
                      input logic [7:0] g, input logic [7:0] e, input logic [7:0] l);
    exp_t x;
    x = '{res, ch, g, e, l};
    case (idx)
      0: begin if0.a = a; if0.b = b; if0.clr_cnt = clr; if0.in_valid = 1'b1; q0.push_back(x); end
      1: begin if1.a = a; if1.b = b; if1.clr_cnt = clr; if1.in_valid = 1'b1; q1.push_back(x); end
      default: begin if2.a = a; if2.b = b; if2.clr_cnt = clr; if2.in_valid = 1'b1; q2.push_back(x); end
    endcase
    @(negedge clk);
    case (idx)
      0: begin if0.in_valid = 1'b0; if0.clr_cnt = 1'b0; end
      1: begin if1.in_valid = 1'b0; if1.clr_cnt = 1'b0; end
      default: begin if2.in_valid = 1'b0; if2.clr_cnt = 1'b0; end
    endcase
  endtask

  task automatic mon(input int idx, input logic [2:0] res, input logic ch,
                     input logic [7:0] g, input logic [7:0] e, input logic [7:0] l);
    exp_t x;
    logic have;
    have = 1'b0;
    case (idx)
      0: if (q0.size() > 0) begin x = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin x = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin x = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_out_valid dut%0d: got out_valid=1 expected 0", idx);
    end else begin
      chk($sformatf("res_dut%0d", idx), 32'(res), 32'(x.res));
      chk($sformatf("changed_dut%0d", idx), 32'(ch), 32'(x.ch));
      chk($sformatf("gt_cnt_dut%0d", idx), 32'(g), 32'(x.g));
      chk($sformatf("eq_cnt_dut%0d", idx), 32'(e), 32'(x.e));
      chk($sformatf("lt_cnt_dut%0d", idx), 32'(l), 32'(x.l));
    end
  endtask

  always @(negedge clk) begin
    if (if0.out_valid)
      mon(0, {if0.gt, if0.eq, if0.lt}, if0.changed, if0.gt_cnt, if0.eq_cnt, if0.lt_cnt);
    if (if1.out_valid)
      mon(1, {if1.gt, if1.eq, if1.lt}, if1.changed, if1.gt_cnt, if1.eq_cnt, if1.lt_cnt);
    if (if2.out_valid)
      mon(2, {if2.gt, if2.eq, if2.lt}, if2.changed, 8'(if2.gt_cnt), 8'(if2.eq_cnt), 8'(if2.lt_cnt));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    if0.enable = 1'b1; if0.in_valid = 1'b1; if0.a = 8'd5; if0.b = 8'd3; if0.clr_cnt = 1'b0;
    if1.enable = 1'b0; if1.in_valid = 1'b0; if1.a = '0;   if1.b = '0;   if1.clr_cnt = 1'b0;
    if2.enable = 1'b0; if2.in_valid = 1'b0; if2.a = '0;   if2.b = '0;   if2.clr_cnt = 1'b0;

    // Reset held across edges with a live sample: everything stays cleared.
    repeat (2) @(negedge clk);
    chk("rst_res", 32'({if0.gt, if0.eq, if0.lt}), 32'd0);
    chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
    chk("rst_gt_cnt", 32'(if0.gt_cnt), 32'd0);
    chk("rst_state", 32'(if0.state), 32'h2);
    reset = 1'b0;
    if0.in_valid = 1'b0;
    #1 chk("state_before_edge", 32'(if0.state), 32'h2);
    @(negedge clk);
    chk("state_after_release", 32'(if0.state), 32'h0);
    chk("state_paused_dut1", 32'(if1.state), 32'h1);

    // Unsigned compares, back to back.
    send(0, 8'd200, 8'd100, 1'b0, 3'b100, 1'b1, 8'd1, 8'd0, 8'd0);
    send(0, 8'd7,   8'd7,   1'b0, 3'b010, 1'b1, 8'd1, 8'd1, 8'd0);
    send(0, 8'd0,   8'd255, 1'b0, 3'b001, 1'b1, 8'd1, 8'd1, 8'd1);
    @(negedge clk);

    // Signed compares: -1 < 1, then -128 < 127 with no change.
    if1.enable = 1'b1;
    send(1, 8'hFF, 8'h01, 1'b0, 3'b001, 1'b1, 8'd0, 8'd0, 8'd1);
    send(1, 8'h80, 8'h7F, 1'b0, 3'b001, 1'b0, 8'd0, 8'd0, 8'd2);

    // Pause: sample dropped, outputs hold.
    if0.enable = 1'b0; if0.in_valid = 1'b1; if0.a = 8'd9; if0.b = 8'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("pause_state", 32'(if0.state), 32'h1);
      chk("pause_res", 32'({if0.gt, if0.eq, if0.lt}), 32'b001);
      chk("pause_gt_cnt", 32'(if0.gt_cnt), 32'd1);
    end
    if0.enable = 1'b1; if0.in_valid = 1'b0;
    @(negedge clk);
    chk("resume_state", 32'(if0.state), 32'h0);
    send(0, 8'd9, 8'd1, 1'b0, 3'b100, 1'b1, 8'd2, 8'd1, 8'd1);

    // Saturation on 2-bit counters, then clear combined with an accept.
    if2.enable = 1'b1;
    send(2, 8'd3, 8'd1, 1'b0, 3'b100, 1'b1, 8'd1, 8'd0, 8'd0);
    send(2, 8'd3, 8'd1, 1'b0, 3'b100, 1'b0, 8'd2, 8'd0, 8'd0);
    send(2, 8'd3, 8'd1, 1'b0, 3'b100, 1'b0, 8'd3, 8'd0, 8'd0);
    send(2, 8'd3, 8'd1, 1'b0, 3'b100, 1'b0, 8'd3, 8'd0, 8'd0);
    send(2, 8'd3, 8'd1, 1'b0, 3'b100, 1'b0, 8'd3, 8'd0, 8'd0);
    send(2, 8'd4, 8'd4, 1'b1, 3'b010, 1'b1, 8'd0, 8'd1, 8'd0);

    // Clear alone: counters zero, flags untouched, no pulse.
    if2.clr_cnt = 1'b1;
    @(negedge clk);
    if2.clr_cnt = 1'b0;
    chk("clr_only_eq_cnt", 32'(if2.eq_cnt), 32'd0);
    chk("clr_only_res", 32'({if2.gt, if2.eq, if2.lt}), 32'b010);

    // Clear honoured while paused; the concurrent sample is dropped.
    if1.enable = 1'b0; if1.clr_cnt = 1'b1; if1.in_valid = 1'b1; if1.a = 8'd0; if1.b = 8'd5;
    @(negedge clk);
    if1.clr_cnt = 1'b0; if1.in_valid = 1'b0;
    chk("paused_clr_lt_cnt", 32'(if1.lt_cnt), 32'd0);
    chk("paused_clr_res", 32'({if1.gt, if1.eq, if1.lt}), 32'b001);
    chk("paused_clr_state", 32'(if1.state), 32'h1);

    // Asynchronous reset between edges.
    chk("pre_reset_gt_cnt", 32'(if0.gt_cnt), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("async_res", 32'({if0.gt, if0.eq, if0.lt}), 32'd0);
    chk("async_gt_cnt", 32'(if0.gt_cnt), 32'd0);
    chk("async_eq_cnt", 32'(if0.eq_cnt), 32'd0);
    chk("async_lt_cnt", 32'(if0.lt_cnt), 32'd0);
    chk("async_state", 32'(if0.state), 32'h2);
    chk("async_res_dut2", 32'({if2.gt, if2.eq, if2.lt}), 32'd0);
    chk("async_state_dut2", 32'(if2.state), 32'h2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
